// File: rtl/loop_ctr_stack.sv
`default_nettype none
// ============================================================================
// Module   : loop_ctr_stack
// Brief    : Loadable saturating down-counter with a LIFO of saved counts,
//            used to run nested loops (push outer count / pop to restore).
// Revision : 1.0 - initial release
// ============================================================================
module loop_ctr_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             push,
    input  logic             pop,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] c_DEPTH_MAX = DW'(DEPTH);

    logic [WIDTH-1:0] data_q, data_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic [DW-1:0]    w_depth_m1;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_pop_idx;
    logic             w_push_ok;

    assign w_empty    = (depth_q == '0);
    assign w_full     = (depth_q == c_DEPTH_MAX);
    assign w_depth_m1 = depth_q - 1'b1;
    // Truncation is safe: push only indexes when depth < DEPTH, pop when depth > 0.
    assign w_push_idx = depth_q[AW-1:0];
    assign w_pop_idx  = w_depth_m1[AW-1:0];
    assign w_push_ok  = push && !w_full;

    always_comb begin
        data_d  = data_q;
        depth_d = depth_q;
        err_d   = err_q;
        if (push) begin
            if (w_full) begin
                err_d = 1'b1;
            end else begin
                data_d  = load_data;
                depth_d = depth_q + 1'b1;
            end
        end else if (pop) begin
            if (w_empty) begin
                err_d = 1'b1;
            end else begin
                data_d  = stack_q[w_pop_idx];
                depth_d = w_depth_m1;
            end
        end else if (load) begin
            data_d = load_data;
        end else if (dec) begin
            if (data_q != '0) begin
                data_d = data_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack entries carry no reset; only depth decides which are valid.
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            stack_q[w_push_idx] <= data_q;
        end
    end

    assign data_out = data_q;
    assign zero     = (data_q == '0);
    assign depth    = depth_q;
    assign empty    = w_empty;
    assign full     = w_full;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: doc/loop_ctr_stack.md
Name: loop_ctr_stack

Overview:
- Loadable, decrementing loop counter with a LIFO of saved counter values. It is the down-counting counterpart of the incrementing address register.
- The matrix-multiply core's control unit uses it to run nested loops (row / column / inner-product). The control unit loads a trip count, decrements it once per iteration and tests zero to exit.
- To enter a nested loop, the control unit pushes the outer count and loads the inner count in one command. When the inner loop finishes, it pops to restore the outer count.

Parameters:
- WIDTH, 16, bit width of counter and stack entries
- DEPTH, 4, number of saved entries in the stack (nesting levels beyond the active one)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load  in  1  replace active counter with load_data
- push  in  1  save active counter to stack, then load load_data as the new active counter
- pop  in  1  restore active counter from the top of the stack
- dec  in  1  decrement active counter by 1
- load_data  in  WIDTH  value used by load and push
- data_out  out  WIDTH  active counter (registered)
- zero  out  1  data_out == 0
- depth  out  $clog2(DEPTH+1)  number of saved entries, 0..DEPTH
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Reset is synchronous and active-high. When reset is sampled high:
  - data_out = 0, depth = 0, err = 0.
  - Hence zero = 1, empty = 1, full = 0.
  - Stack contents become don't-care.
- Reset mid-operation discards all saved entries. Reset overrides every command in the same cycle.
- Command priority, one command per cycle: reset > push > pop > load > dec.
  - Only the highest-priority asserted command executes.
  - Lower-priority commands asserted in the same cycle are ignored, not queued.
- Latency: a command sampled at edge N is visible on data_out/depth/flags after edge N (one-cycle latency). No combinational path from command inputs to outputs.
- zero, empty and full are decoded from registered state only.
- push:
  - If not full: stack[depth] <= data_out, data_out <= load_data, depth <= depth+1.
  - If full: no state change, err <= 1.
- pop:
  - If not empty: data_out <= stack[depth-1], depth <= depth-1.
  - If empty: no state change, err <= 1.
- load: data_out <= load_data. Depth is unchanged.
- dec:
  - If data_out != 0: data_out <= data_out-1.
  - If data_out == 0: data_out stays 0 (saturate, no wrap to all-ones) and err is unaffected.
- err is cleared only by reset.
- Width rules:
  - Unsigned arithmetic.
  - load_data of 0 is legal and makes zero = 1 next cycle.
  - Maximum value 2^WIDTH-1 decrements normally.
- Idle (no command): all state holds.
- Stack storage is plain registers, with no reset requirement on entries. Depth is always at most DEPTH, and the illegal depth values cannot be reached.

Test Plan:
- Reset, then load with load_data=3 and dec held for 4 cycles:
  - data_out goes 3,2,1,0,0.
  - zero=1 from the cycle after reaching 0.
  - err=0 throughout.
- Nesting sequence:
  - load 5; push with load_data=2; dec, dec → data_out=0, depth=1.
  - pop → data_out=5, depth=0, empty=1.
- Overflow:
  - load 9, then push 10, 11, 12, 13 → depth=4, full=1, data_out=13.
  - A 5th push of 14 → data_out stays 13, depth stays 4, err=1.
  - Four pops then return data_out = 12, 11, 10, 9.
- Underflow: after reset, pop → data_out=0, depth=0, err=1. err stays 1 through later load 7 and dec until reset.
- Simultaneous commands:
  - With data_out=4, depth=0: assert push(load_data=8), pop, load and dec together → push wins, data_out=8, depth=1.
  - Next cycle assert load(load_data=1) and dec → data_out=1.
- Reset mid-operation: with depth=3 and data_out=6, assert reset together with push → data_out=0, depth=0, empty=1, err=0.
